mem_access: RTL
===============

Name: mem_access

Overview:
- Memory stage sitting directly upstream of writeback.
- Turns the execute-stage address and store data into data-memory requests: aligned word address, per-byte write enables, lane-shifted write data.
- Splits misaligned word and halfword accesses into two back-to-back aligned accesses, stalling upstream for one cycle.
- Registers the pipeline fields writeback consumes, including the is_misaligned marker that writeback pairs with the next cycle's mem_result.

Parameters:
- SPLIT_EN, 1: 1 = split misaligned accesses; 0 = do not access memory and raise EXC_MISALIGNED instead.
- EXC_MISALIGNED, 8'h04: exception code used when SPLIT_EN=0.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- halt  in  1  freeze all state and registered outputs; suppress memory writes
- flush  in  1  kill the current instruction and any split in progress
- bubble_in  in  1  incoming slot is empty
- opcode_in  in  5  3-5 word, 6-8 half, 9-11 byte memory ops
- tgt_in_1, tgt_in_2  in  5 each  destination registers
- is_load_in, is_store_in  in  1 each  memory op class
- alu_result_1_in  in  32  byte address for memory ops, otherwise result
- alu_result_2_in  in  32  second result
- store_data_in  in  32  value to store, right-justified
- exc_in  in  8  exception code from earlier stages
- mem_addr  out  32  word-aligned address, bits [1:0]=0
- mem_re  out  1  read request
- mem_we  out  4  byte write enables; bit i = byte lane i (bits 8i+7:8i)
- mem_wdata  out  32  lane-aligned store data
- stall_out  out  1  hold upstream stages this cycle
- bubble_out, opcode_out, tgt_out_1, tgt_out_2, is_load_out, is_store_out, is_misaligned_out, alu_result_1_out, alu_result_2_out, addr_out, exc_out  out  registered copies of the inputs plus split marker, to writeback

Behaviour:
- Memory model: synchronous, byte-addressed, one-cycle read latency. A request in cycle N returns data in N+1, when the instruction sits in writeback.
- Let k = alu_result_1_in[1:0] and A = {alu_result_1_in[31:2],2'b00}.
- Active memory op: bubble_in=0, exc_in=0, (is_load_in|is_store_in), flush=0.
- Inactive op: mem_re=0, mem_we=0.
- Misaligned condition: word with k!=0, or half with k=3. A half at k=0..2 and any byte op are aligned.
- States: IDLE, SECOND.
- IDLE, aligned active op:
  - mem_addr=A; mem_re=is_load_in.
  - Stores: mem_we = word 4'b1111, half 4'b0011<<k, byte 4'b0001<<k; mem_wdata = store_data_in<<(8k).
  - Register the inputs to the outputs with is_misaligned_out=0.
- IDLE, misaligned active op with SPLIT_EN=1:
  - First access at A: mem_we = (word 4'b1111<<k, half 4'b1000) truncated to 4 bits; mem_wdata = data<<(8k).
  - stall_out=1. Outputs: bubble_out=1, is_misaligned_out=1, addr_out=original address, other fields copied.
  - Latch the instruction. Go to SECOND.
- SECOND:
  - Use the latched instruction, ignore inputs. mem_addr=A+4, wrapping 32'hFFFFFFFC -> 32'h0.
  - Stores: mem_we = word 4'b1111>>(4-k), half 4'b0001; mem_wdata = data>>(32-8k), or data>>8 for half.
  - stall_out=0. Outputs: bubble_out=0, is_misaligned_out=0, fields from the latch. Return to IDLE.
- Misaligned op with SPLIT_EN=0: no memory access; exc_out=EXC_MISALIGNED; instruction passes through unsplit.
- exc_in!=0: no memory access; exc_out=exc_in; fields pass through.
- halt=1:
  - No state change; registered outputs hold.
  - mem_we forced to 0; mem_re may stay asserted.
  - stall_out reflects the frozen state.
  - A halted SECOND resumes in SECOND.
- flush=1: state goes to IDLE; next bubble_out=1, is_misaligned_out=0, no memory write that cycle. Flush beats halt.
- Reset, synchronous, active-high, beats everything:
  - state=IDLE; bubble_out=1; is_misaligned_out=0; is_load_out=is_store_out=0; exc_out=0.
  - tgt_out_1=tgt_out_2=0; opcode_out=0; alu_result_*_out=0; addr_out=0.
  - Combinational mem_we/mem_re forced to 0 while rst=1.
- Non-memory ops pass through with a 1-cycle latency and no memory request.

Test Plan:
- Aligned LW at 0x100, memory holds 0xDEADBEEF -> mem_addr=0x100, mem_re=1, no stall; next cycle bubble_out=0, is_misaligned_out=0.
- Misaligned LW at 0x101 -> cycle 1: mem_addr=0x100, stall_out=1, bubble_out=1, is_misaligned_out=1; cycle 2: mem_addr=0x104, bubble_out=0; writeback result = {mem[0x104][7:0], mem[0x100][31:8]}.
- SW 0x11223344 at 0x102 -> access 1: mem_we=4'b1100, wdata=0x33440000 @0x100; access 2: mem_we=4'b0011, wdata=0x00001122 @0x104.
- SH 0xABCD at 0xFFFFFFFF -> access 1: mem_we=4'b1000, wdata=0xCD000000 @0xFFFFFFFC; access 2: mem_we=4'b0001, wdata=0x000000AB @0x0.
- SB at 0x203 with exc_in=8'h02 -> mem_we=0, mem_re=0, exc_out=8'h02; then flush asserted during SECOND of a split LW -> no second access, next bubble_out=1, state IDLE.
- rst asserted during SECOND -> next cycle bubble_out=1, stall_out=0, all registered outputs 0; halt held for 3 cycles mid-split -> outputs frozen, mem_we=0, split completes after halt drops.

Source files
------------

// File: rtl/mem_access.sv
// mem_access: memory stage between execute and writeback.
// Builds data-memory requests (word address, byte enables, lane-shifted store
// data) and splits misaligned word/halfword accesses into two aligned accesses,
// stalling upstream for one cycle. Registers the fields writeback consumes.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   halt, flush               freeze stage / kill current instruction
//   bubble_in .. exc_in       execute-stage instruction fields
//   mem_addr/re/we/wdata      combinational data-memory request
//   stall_out                 hold upstream stages this cycle
//   *_out                     registered fields to writeback
module mem_access #(
   parameter bit         SPLIT_EN       = 1'b1,
   parameter logic [7:0] EXC_MISALIGNED = 8'h04
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        halt,
   input  logic        flush,
   input  logic        bubble_in,
   input  logic [4:0]  opcode_in,
   input  logic [4:0]  tgt_in_1,
   input  logic [4:0]  tgt_in_2,
   input  logic        is_load_in,
   input  logic        is_store_in,
   input  logic [31:0] alu_result_1_in,
   input  logic [31:0] alu_result_2_in,
   input  logic [31:0] store_data_in,
   input  logic [7:0]  exc_in,
   output logic [31:0] mem_addr,
   output logic        mem_re,
   output logic [3:0]  mem_we,
   output logic [31:0] mem_wdata,
   output logic        stall_out,
   output logic        bubble_out,
   output logic [4:0]  opcode_out,
   output logic [4:0]  tgt_out_1,
   output logic [4:0]  tgt_out_2,
   output logic        is_load_out,
   output logic        is_store_out,
   output logic        is_misaligned_out,
   output logic [31:0] alu_result_1_out,
   output logic [31:0] alu_result_2_out,
   output logic [31:0] addr_out,
   output logic [7:0]  exc_out
);

   typedef enum logic [0:0] {StIdle, StSecond} state_e;

   state_e state_q, state_d;

   // Instruction held across the second half of a split access.
   logic [4:0]  lat_opcode_q, lat_tgt1_q, lat_tgt2_q;
   logic        lat_load_q, lat_store_q;
   logic [31:0] lat_alu1_q, lat_alu2_q, lat_data_q;

   logic [4:0]  sel_opcode;
   logic        sel_load, sel_store;
   logic [31:0] sel_addr, sel_data;
   logic [1:0]  k;
   logic [31:0] base;
   logic        is_word, is_half, is_byte;
   logic        misaligned, in_active, start_split, mis_exc, do_access;
   logic [3:0]  we_pat;

   always_comb begin
      sel_opcode  = opcode_in;
      sel_load    = is_load_in;
      sel_store   = is_store_in;
      sel_addr    = alu_result_1_in;
      sel_data    = store_data_in;
      if (state_q == StSecond) begin
         sel_opcode = lat_opcode_q;
         sel_load   = lat_load_q;
         sel_store  = lat_store_q;
         sel_addr   = lat_alu1_q;
         sel_data   = lat_data_q;
      end
      k       = sel_addr[1:0];
      base    = {sel_addr[31:2], 2'b00};
      is_word = (sel_opcode >= 5'd3) && (sel_opcode <= 5'd5);
      is_half = (sel_opcode >= 5'd6) && (sel_opcode <= 5'd8);
      is_byte = (sel_opcode >= 5'd9) && (sel_opcode <= 5'd11);

      misaligned  = (is_word && (k != 2'd0)) || (is_half && (k == 2'd3));
      in_active   = !bubble_in && (exc_in == 8'h00) && (is_load_in || is_store_in) && !flush;
      start_split = (state_q == StIdle) && in_active && misaligned && SPLIT_EN;
      mis_exc     = (state_q == StIdle) && !bubble_in && (exc_in == 8'h00) &&
                    (is_load_in || is_store_in) && misaligned && !SPLIT_EN;

      mem_addr  = base;
      we_pat    = 4'b0000;
      mem_wdata = sel_data << {k, 3'b000};
      if (state_q == StSecond) begin
         do_access = !flush;
         mem_addr  = base + 32'd4;
         if (is_half) begin
            we_pat    = 4'b0001;
            mem_wdata = sel_data >> 8;
         end else begin
            we_pat    = 4'b1111 >> (3'd4 - {1'b0, k});
            mem_wdata = sel_data >> (6'd32 - {1'b0, k, 3'b000});
         end
      end else begin
         do_access = in_active && !(misaligned && !SPLIT_EN);
         // Truncation to 4 bits yields the first-half lanes of a split access.
         if (is_word)      we_pat = 4'b1111 << k;
         else if (is_half) we_pat = 4'b0011 << k;
         else if (is_byte) we_pat = 4'b0001 << k;
      end

      mem_we    = (do_access && sel_store && !halt && !rst) ? we_pat : 4'b0000;
      mem_re    = do_access && sel_load && !rst;
      stall_out = start_split && !rst;
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = StIdle;
      end else if (!halt) begin
         unique case (state_q)
            StIdle:   state_d = start_split ? StSecond : StIdle;
            StSecond: state_d = StIdle;
            default:  state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (!rst && !flush && !halt && start_split) begin
         lat_opcode_q <= opcode_in;
         lat_tgt1_q   <= tgt_in_1;
         lat_tgt2_q   <= tgt_in_2;
         lat_load_q   <= is_load_in;
         lat_store_q  <= is_store_in;
         lat_alu1_q   <= alu_result_1_in;
         lat_alu2_q   <= alu_result_2_in;
         lat_data_q   <= store_data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bubble_out        <= 1'b1;
         opcode_out        <= '0;
         tgt_out_1         <= '0;
         tgt_out_2         <= '0;
         is_load_out       <= 1'b0;
         is_store_out      <= 1'b0;
         is_misaligned_out <= 1'b0;
         alu_result_1_out  <= '0;
         alu_result_2_out  <= '0;
         addr_out          <= '0;
         exc_out           <= '0;
      end else if (flush) begin
         bubble_out        <= 1'b1;
         is_misaligned_out <= 1'b0;
         is_load_out       <= 1'b0;
         is_store_out      <= 1'b0;
      end else if (!halt) begin
         if (state_q == StSecond) begin
            bubble_out        <= 1'b0;
            opcode_out        <= lat_opcode_q;
            tgt_out_1         <= lat_tgt1_q;
            tgt_out_2         <= lat_tgt2_q;
            is_load_out       <= lat_load_q;
            is_store_out      <= lat_store_q;
            is_misaligned_out <= 1'b0;
            alu_result_1_out  <= lat_alu1_q;
            alu_result_2_out  <= lat_alu2_q;
            addr_out          <= lat_alu1_q;
            exc_out           <= 8'h00;
         end else begin
            bubble_out        <= bubble_in || start_split;
            opcode_out        <= opcode_in;
            tgt_out_1         <= tgt_in_1;
            tgt_out_2         <= tgt_in_2;
            is_load_out       <= is_load_in;
            is_store_out      <= is_store_in;
            is_misaligned_out <= start_split;
            alu_result_1_out  <= alu_result_1_in;
            alu_result_2_out  <= alu_result_2_in;
            addr_out          <= alu_result_1_in;
            exc_out           <= mis_exc ? EXC_MISALIGNED : exc_in;
         end
      end
   end

endmodule
